// File: rtl/clk_div_gen_if.sv
// Control and status bundle for clk_div_gen: tap/divider controls in, taps and strobes out.
interface clk_div_gen_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
);
  logic             en;
  logic [WIDTH-1:0] tap_mask;
  logic             mode;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic [WIDTH-1:0] taps;
  logic             y;
  logic             div_out;
  logic             tick;
  logic             div_ack;

  modport master (
    output en, tap_mask, mode, div_val, div_load,
    input  taps, y, div_out, tick, div_ack
  );

  modport slave (
    input  en, tap_mask, mode, div_val, div_load,
    output taps, y, div_out, tick, div_ack
  );
endinterface

// File: rtl/clk_div_gen.sv
// Synchronous power-of-two taps, registered tap combine and a reloadable divided clock.
// Define CLK_DIV_GEN_IMMEDIATE_LOAD_EN to apply div_load on the next edge instead of at terminal count.
module clk_div_gen #(
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 0
) (
  input logic          i_clk,
  input logic          i_rst,
  clk_div_gen_if.slave bus
);
  localparam logic [DIV_W-1:0] ACTIVE_INIT = DIV_W'(DIV_INIT);

  logic [WIDTH-1:0] r_cnt;
  logic             r_y;
  logic [DIV_W-1:0] r_pcnt;
  logic [DIV_W-1:0] r_active;
  logic             r_div_out;
  logic             r_tick;
  logic             r_ack;
  logic             w_tc;

  function automatic logic combine(input logic [WIDTH-1:0] cnt,
                                   input logic [WIDTH-1:0] mask,
                                   input logic             mode);
    logic [WIDTH-1:0] sel;
    sel = cnt & mask;
    if (mode) begin
      return |sel;
    end else begin
      return (mask != '0) && (sel == mask);
    end
  endfunction

  assign w_tc = bus.en && (r_pcnt == r_active);

  // Free-running tap counter; y samples the pre-increment count so it trails taps by a cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_y   <= 1'b0;
    end else if (bus.en) begin
      r_cnt <= r_cnt + WIDTH'(1);
      r_y   <= combine(r_cnt, bus.tap_mask, bus.mode);
    end
  end

`ifdef CLK_DIV_GEN_IMMEDIATE_LOAD_EN
  // A load restarts the half-period from zero without disturbing the div_out level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pcnt    <= '0;
      r_active  <= ACTIVE_INIT;
      r_div_out <= 1'b0;
      r_tick    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_ack  <= 1'b0;
      if (bus.div_load) begin
        r_active <= bus.div_val;
        r_pcnt   <= '0;
        r_ack    <= 1'b1;
      end else if (w_tc) begin
        r_pcnt    <= '0;
        r_div_out <= ~r_div_out;
        r_tick    <= 1'b1;
      end else if (bus.en) begin
        r_pcnt <= r_pcnt + DIV_W'(1);
      end
    end
  end
`else
  logic             r_pend;
  logic [DIV_W-1:0] r_pend_val;

  // New divisors only take over at a terminal count, so every half-period is whole
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pcnt     <= '0;
      r_active   <= ACTIVE_INIT;
      r_div_out  <= 1'b0;
      r_tick     <= 1'b0;
      r_ack      <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else begin
      r_tick <= 1'b0;
      r_ack  <= 1'b0;
      if (w_tc) begin
        r_pcnt    <= '0;
        r_div_out <= ~r_div_out;
        r_tick    <= 1'b1;
        r_pend    <= 1'b0;
        if (bus.div_load) begin
          r_active <= bus.div_val;
          r_ack    <= 1'b1;
        end else if (r_pend) begin
          r_active <= r_pend_val;
          r_ack    <= 1'b1;
        end
      end else begin
        if (bus.en) begin
          r_pcnt <= r_pcnt + DIV_W'(1);
        end
        if (bus.div_load) begin
          r_pend     <= 1'b1;
          r_pend_val <= bus.div_val;
        end
      end
    end
  end
`endif

  assign bus.taps    = r_cnt;
  assign bus.y       = r_y;
  assign bus.div_out = r_div_out;
  assign bus.tick    = r_tick;
  assign bus.div_ack = r_ack;
endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus randomized traffic against a countdown model.
module tb_clk_div_gen;
  localparam int WIDTH    = 4;
  localparam int DIV_W    = 8;
  localparam int DIV_INIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  clk_div_gen_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

  clk_div_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Reference model: tap counter, y from previous count, divider as "enabled cycles left until toggle"
  logic [WIDTH-1:0] m_cnt;
  logic             m_y, m_out, m_tick, m_ack, m_pend;
  int               m_left, m_active, m_pval;

  task automatic model_reset();
    m_cnt = '0; m_y = 1'b0; m_out = 1'b0; m_tick = 1'b0; m_ack = 1'b0;
    m_pend = 1'b0; m_pval = 0; m_active = DIV_INIT; m_left = DIV_INIT + 1;
  endtask

  task automatic model_update();
    logic all_set, any_set;
    m_tick = 1'b0;
    m_ack  = 1'b0;
    if (bus.en) begin
      all_set = (bus.tap_mask != '0);
      any_set = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
        if (bus.tap_mask[k]) begin
          all_set = all_set & m_cnt[k];
          any_set = any_set | m_cnt[k];
        end
      end
      m_y   = bus.mode ? any_set : all_set;
      m_cnt = m_cnt + 4'd1;
    end
`ifdef CLK_DIV_GEN_IMMEDIATE_LOAD_EN
    if (bus.div_load) begin
      m_active = int'(bus.div_val);
      m_left   = m_active + 1;
      m_ack    = 1'b1;
    end else if (bus.en) begin
      m_left--;
      if (m_left == 0) begin
        m_out  = ~m_out;
        m_tick = 1'b1;
        m_left = m_active + 1;
      end
    end
`else
    if (bus.en) m_left--;
    if (bus.en && m_left == 0) begin
      m_out  = ~m_out;
      m_tick = 1'b1;
      if (bus.div_load) begin
        m_active = int'(bus.div_val);
        m_ack    = 1'b1;
      end else if (m_pend) begin
        m_active = m_pval;
        m_ack    = 1'b1;
      end
      m_pend = 1'b0;
      m_left = m_active + 1;
    end else if (bus.div_load) begin
      m_pend = 1'b1;
      m_pval = int'(bus.div_val);
    end
`endif
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0; bus.tap_mask = '0; bus.mode = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({bus.taps, bus.y, bus.div_out, bus.tick, bus.div_ack} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {bus.taps, bus.y, bus.div_out, bus.tick, bus.div_ack});
    end
  endtask

  task automatic test_taps();
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) clk_step();
    n_tests++;
    if (bus.taps !== 4'b1000) begin
      n_fail++; $display("FAIL taps_8: got %b required 1000", bus.taps);
    end
    for (int i = 0; i < 8; i++) clk_step();
    n_tests++;
    if (bus.taps !== 4'b0000) begin
      n_fail++; $display("FAIL taps_wrap: got %b required 0000", bus.taps);
    end
  endtask

  task automatic test_combine();
    int highs;
    for (int md = 0; md < 2; md++) begin
      do_reset();
      bus.en = 1'b1; bus.tap_mask = 4'b0101; bus.mode = md[0];
      clk_step();
      highs = 0;
      for (int i = 0; i < 16; i++) begin
        clk_step();
        if (bus.y === 1'b1) highs++;
        n_tests++;
        if (bus.y !== m_y) begin
          n_fail++; $display("FAIL combine_y mode%0d cyc%0d: got %b required %b", md, i, bus.y, m_y);
        end
      end
      n_tests++;
      if (highs !== ((md == 0) ? 4 : 12)) begin
        n_fail++; $display("FAIL combine_count mode%0d: got %0d highs required %0d", md, highs, (md == 0) ? 4 : 12);
      end
      bus.tap_mask = 4'b0000;
      highs = 0;
      for (int i = 0; i < 18; i++) begin
        clk_step();
        if (i > 0 && bus.y !== 1'b0) highs++;
      end
      n_tests++;
      if (highs !== 0) begin
        n_fail++; $display("FAIL combine_mask0 mode%0d: got %0d y highs required 0", md, highs);
      end
    end
  endtask

  task automatic test_divider();
    int rise_at, ticks;
    do_reset();
    bus.en = 1'b1;
    rise_at = -1; ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      clk_step();
      if (bus.div_out === 1'b1 && rise_at < 0) rise_at = i;
      if (bus.tick === 1'b1) ticks++;
      n_tests++;
      if ({bus.div_out, bus.tick} !== {m_out, m_tick}) begin
        n_fail++; $display("FAIL div_init cyc%0d: got out/tick %b%b required %b%b", i, bus.div_out, bus.tick, m_out, m_tick);
      end
    end
    n_tests++;
    if (rise_at !== 3) begin
      n_fail++; $display("FAIL div_first_rise: got cycle %0d required 3", rise_at);
    end
    n_tests++;
    if (ticks !== 4) begin
      n_fail++; $display("FAIL div_tick_rate: got %0d ticks required 4", ticks);
    end
    bus.div_load = 1'b1; bus.div_val = 8'd0;
    clk_step();
    bus.div_load = 1'b0;
    for (int i = 0; i < 10 && bus.div_ack !== 1'b1; i++) clk_step();
    n_tests++;
    if (bus.div_ack !== 1'b1) begin
      n_fail++; $display("FAIL div_load0_ack: got %b required 1 within budget", bus.div_ack);
    end
    for (int i = 0; i < 6; i++) begin
      clk_step();
      n_tests++;
      if (bus.tick !== 1'b1 || bus.div_out !== m_out) begin
        n_fail++; $display("FAIL div_active0 cyc%0d: got out/tick %b%b required %b1", i, bus.div_out, bus.tick, m_out);
      end
    end
  endtask

  task automatic test_en_hold();
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) clk_step();
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      n_tests++;
      if (bus.tick !== 1'b0 || bus.taps !== 4'd4 || bus.div_out !== m_out || bus.y !== m_y) begin
        n_fail++; $display("FAIL en_hold cyc%0d: got taps %0d out %b tick %b required taps 4 out %b tick 0",
                           i, bus.taps, bus.div_out, bus.tick, m_out);
      end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clk_step();
      n_tests++;
      if ({bus.taps, bus.div_out, bus.tick} !== {m_cnt, m_out, m_tick}) begin
        n_fail++; $display("FAIL en_resume cyc%0d: got %b required %b", i, {bus.taps, bus.div_out, bus.tick}, {m_cnt, m_out, m_tick});
      end
    end
  endtask

`ifdef CLK_DIV_GEN_IMMEDIATE_LOAD_EN
  task automatic test_immediate_load();
    do_reset();
    bus.en = 1'b1; bus.div_load = 1'b1; bus.div_val = 8'd5;
    clk_step();
    bus.div_load = 1'b0;
    clk_step();
    clk_step();
    bus.div_load = 1'b1; bus.div_val = 8'd3;
    clk_step();
    bus.div_load = 1'b0;
    n_tests++;
    if ({bus.div_ack, bus.tick, bus.div_out} !== 3'b100) begin
      n_fail++; $display("FAIL imm_load_edge: got ack/tick/out %b required 100", {bus.div_ack, bus.tick, bus.div_out});
    end
    for (int i = 1; i <= 4; i++) begin
      clk_step();
      n_tests++;
      if (bus.div_out !== (i == 4) || bus.div_out !== m_out) begin
        n_fail++; $display("FAIL imm_next_toggle cyc%0d: got %b required %b", i, bus.div_out, (i == 4));
      end
    end
  endtask
`else
  task automatic test_deferred_load();
    int acks, ticks;
    do_reset();
    bus.en = 1'b1; bus.div_load = 1'b1; bus.div_val = 8'd4;
    clk_step();
    bus.div_load = 1'b0;
    for (int i = 0; i < 10 && bus.div_ack !== 1'b1; i++) clk_step();
    n_tests++;
    if (bus.div_ack !== 1'b1) begin
      n_fail++; $display("FAIL defer_setup_ack: got %b required 1 within budget", bus.div_ack);
    end
    clk_step();
    bus.div_load = 1'b1; bus.div_val = 8'd1;
    clk_step();
    bus.div_val = 8'd0;
    clk_step();
    bus.div_load = 1'b0;
    acks = 0; ticks = 0;
    for (int i = 0; i < 6; i++) begin
      clk_step();
      if (bus.div_ack === 1'b1) acks++;
      if (bus.tick === 1'b1) ticks++;
      n_tests++;
      if ({bus.div_out, bus.tick, bus.div_ack} !== {m_out, m_tick, m_ack}) begin
        n_fail++; $display("FAIL defer_cyc%0d: got out/tick/ack %b required %b", i,
                           {bus.div_out, bus.tick, bus.div_ack}, {m_out, m_tick, m_ack});
      end
    end
    n_tests++;
    if (acks !== 1 || ticks !== 5) begin
      n_fail++; $display("FAIL defer_single_ack: got %0d acks %0d ticks required 1 acks 5 ticks", acks, ticks);
    end
  endtask
`endif

  task automatic test_async_reset();
    int rise_at, acks;
    do_reset();
    bus.en = 1'b1;
    clk_step();
    bus.div_load = 1'b1; bus.div_val = 8'd5;
    clk_step();
    bus.div_load = 1'b0;
    clk_step();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.taps, bus.y, bus.div_out, bus.tick, bus.div_ack} !== 8'h00) begin
      n_fail++; $display("FAIL async_reset: got %b required all zero", {bus.taps, bus.y, bus.div_out, bus.tick, bus.div_ack});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    rise_at = -1; acks = 0;
    for (int i = 1; i <= 8; i++) begin
      clk_step();
      if (bus.div_out === 1'b1 && rise_at < 0) rise_at = i;
      if (bus.div_ack === 1'b1) acks++;
    end
    n_tests++;
    if (rise_at !== 3 || acks !== 0) begin
      n_fail++; $display("FAIL post_reset_div: got rise %0d acks %0d required rise 3 acks 0", rise_at, acks);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.en       = ($urandom % 8) != 0;
      bus.div_load = ($urandom % 6) == 0;
      bus.div_val  = DIV_W'($urandom % 4);
      bus.tap_mask = WIDTH'($urandom % 16);
      bus.mode     = 1'($urandom % 2);
      clk_step();
      n_tests++;
      if ({bus.taps, bus.y, bus.div_out, bus.tick, bus.div_ack} !== {m_cnt, m_y, m_out, m_tick, m_ack}) begin
        n_fail++; $display("FAIL random cyc%0d: got %b required %b", i,
                           {bus.taps, bus.y, bus.div_out, bus.tick, bus.div_ack}, {m_cnt, m_y, m_out, m_tick, m_ack});
      end
    end
  endtask

  initial begin
    test_reset();
    test_taps();
    test_combine();
    test_divider();
    test_en_hold();
`ifdef CLK_DIV_GEN_IMMEDIATE_LOAD_EN
    test_immediate_load();
`else
    test_deferred_load();
`endif
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised clock-enable and divided-clock generator that replaces ripple-clocked divider chains with a single synchronous counter in the `clk` domain. It provides WIDTH power-of-two taps, a registered AND/OR combine of selected taps, and one programmable divided output. The divisor can be reloaded at runtime without glitches. It sits between the top-level pin wrapper and any logic needing slow strobes or observable divided clocks on output pins.

## Interface
- WIDTH, 8, number of power-of-two taps (tap k = clk / 2^(k+1)); min 2
- DIV_W, 8, width of programmable divisor
- DIV_INIT, 0, active divisor value after reset
- clk  in  1  single clock; all state is on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- en  in  1  count enable; when low, all counters and outputs hold
- tap_mask  in  WIDTH  taps included in combine
- mode  in  1  combine function: 0 = AND, 1 = OR
- div_val  in  DIV_W  requested half-period minus one
- div_load  in  1  single-cycle request to adopt div_val
- taps  out  WIDTH  free-running counter bits; taps[k] toggles every 2^k enabled cycles
- y  out  1  registered combine of masked taps
- div_out  out  1  programmable divided clock, 50% duty, period 2*(active+1) enabled cycles
- tick  out  1  one-cycle strobe in the cycle div_out changes
- div_ack  out  1  one-cycle pulse in the cycle a new divisor becomes active

## Operation
- Reset: cnt = 0, taps = 0, y = 0, div_out = 0, tick = 0, div_ack = 0, pcnt = 0, active = DIV_INIT, pending flag clear.
- cnt: WIDTH-bit, increments when en = 1, wraps from all-ones to 0 with no special action.
- y: registered from the current cnt, so it lags taps by one cycle.
  - mode 0: y = 1 when tap_mask != 0 and every masked bit is 1.
  - mode 1: y = 1 when any masked bit is 1.
  - tap_mask = 0 gives y = 0 in both modes.
- Programmable divider:
  - pcnt counts 0..active while en = 1.
  - At the terminal count (pcnt == active, en = 1): pcnt <= 0, div_out inverts, tick <= 1.
  - active = 0 gives div_out = clk/2 and tick high every enabled cycle.
- Divisor load, deferred (default):
  - div_load captures div_val into pending and sets the flag.
  - The pending value becomes active at the next terminal count, which also toggles div_out normally. div_ack pulses on that edge and the flag clears.
  - A second div_load while a value is pending overwrites it; only one div_ack results.
  - If div_load coincides with a terminal count, that cycle's div_val is applied directly and div_ack pulses on that edge.
- en low: cnt, pcnt, div_out and y hold. tick is 0. A pending load stays pending.
- Reset asserted mid-operation: every output clears on the reset edge and any pending load is discarded.

## Timing
- taps, y, div_out, tick and div_ack are all flop outputs; there are no combinational paths from inputs to outputs.
- First div_out rise occurs active+1 enabled cycles after reset release.
- tick and the div_out edge occur on the same clk edge.
- Deferred-load latency is at most active_old+1 enabled cycles.

## Configuration
- CLK_DIV_GEN_IMMEDIATE_LOAD_EN defined: div_load applies div_val on the next clk edge regardless of en.
  - pcnt is cleared to 0, div_out keeps its level and no tick is generated.
  - div_ack pulses on that edge and the pending register is not built.
- Macro undefined: deferred behaviour as described under Operation.

## Test plan
- Reset and taps (WIDTH=4, en=1): release reset, run 8 cycles -> taps = 4'b1000. Run 8 more -> taps = 0 (wrap).
- Combine (mask=4'b0101):
  - mode 0: y = 1 exactly one cycle after taps = x1x1 (cnt 5, 7, 13, 15).
  - mode 1: y = 0 one cycle after cnt 0, 2, 8, 10 only.
  - mask = 0 -> y stays 0 in both modes.
- Divider: DIV_INIT=2 -> div_out rises 3 cycles after reset release, period 6, tick high 1 cycle in 3. active = 0 -> div_out period 2.
- Deferred load: active=4, assert div_load with div_val=1 at pcnt=1, then div_load with div_val=0 a cycle later -> single div_ack at the next terminal count; new period 2. Drop en for 5 cycles mid-count -> all outputs frozen, no tick.
- Async reset mid-count while a load is pending -> all outputs 0 without a clk edge. The next terminal count uses DIV_INIT and no div_ack pulses.
- With CLK_DIV_GEN_IMMEDIATE_LOAD_EN: load div_val=3 at pcnt=2 -> div_ack on the next edge with pcnt = 0, div_out unchanged, next toggle 4 cycles later.
